// File: rtl/comparator_pkg.sv
// Shared encodings for the serial comparator: operation codes and FSM states.
package comparator_pkg;

    typedef enum logic [1:0] {
        OpEq = 2'b00,
        OpLt = 2'b01,
        OpLe = 2'b10,
        OpGt = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StScan = 2'b01,
        StDone = 2'b10
    } state_e;

    // Map the final lt/eq decision onto the requested relation.
    function automatic logic apply_op(op_e op_sel, logic lt_v, logic eq_v);
        logic res;
        case (op_sel)
            OpEq:    res = eq_v;
            OpLt:    res = lt_v;
            OpLe:    res = lt_v | eq_v;
            OpGt:    res = ~(lt_v | eq_v);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: scans captured operands MSB first, one bit
// per cycle, and stops at the first differing bit.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             Out,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic             sgn_q, sgn_d;
    logic             out_q, out_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic a_bit, b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    // Next-state logic: capture in idle, scan one bit per cycle, decide on first difference.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        out_d   = out_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op_e'(op);
                    sgn_d   = signed_mode;
                    idx_d   = IdxMax;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (a_bit != b_bit) begin
                    eq_d = 1'b0;
                    // A set sign bit means the more negative operand in signed mode.
                    if (sgn_q && (idx_q == IdxMax)) begin
                        lt_d = a_bit;
                    end else begin
                        lt_d = b_bit;
                    end
                    out_d   = apply_op(op_q, lt_d, eq_d);
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    out_d   = apply_op(op_q, 1'b0, 1'b1);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OpEq;
            sgn_q   <= 1'b0;
            out_q   <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            out_q   <= out_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        Out  = out_q;
        eq   = eq_q;
        lt   = lt_q;
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed and sweep checks for the serial comparator at WIDTH=4.
module tb_serial_comparator;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   op;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic         Out;
    logic         eq;
    logic         lt;

    int errors = 0;
    int checks = 0;

    serial_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .op          (op),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .Out         (Out),
        .eq          (eq),
        .lt          (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic       sgn;
        logic       out;
        logic       eq;
        logic       lt;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: integer compare plus first-difference latency.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                         input logic sgn, output logic m_out, output logic m_eq,
                         output logic m_lt, output int m_lat);
        int sa, sb, k;
        sa = int'(a);
        sb = int'(b);
        if (sgn && a[3]) sa = sa - 16;
        if (sgn && b[3]) sb = sb - 16;
        m_eq = (sa == sb);
        m_lt = (sa < sb);
        case (o)
            2'b00:   m_out = m_eq;
            2'b01:   m_out = m_lt;
            2'b10:   m_out = m_lt | m_eq;
            default: m_out = !(m_lt | m_eq);
        endcase
        k = W;
        for (int i = 0; i < W; i++) begin
            if (a[i] != b[i]) k = W - i;
        end
        m_lat = k + 1;
    endtask

    // Issue one comparison from an idle cycle; returns in the DONE cycle (or on timeout).
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                         input logic sgn, output int lat);
        A           = a;
        B           = b;
        op          = o;
        signed_mode = sgn;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < W + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Step from the DONE cycle into the following idle cycle.
    task automatic finish_done();
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic        m_out, m_eq, m_lt;
    int          m_lat;
    int          saw_done;

    initial begin
        vecs[0] = '{a: 4'd5,  b: 4'd5,  op: 2'b00, sgn: 1'b0, out: 1'b1, eq: 1'b1, lt: 1'b0, lat: 5};
        vecs[1] = '{a: 4'd8,  b: 4'd7,  op: 2'b11, sgn: 1'b0, out: 1'b1, eq: 1'b0, lt: 1'b0, lat: 2};
        vecs[2] = '{a: 4'd8,  b: 4'd7,  op: 2'b01, sgn: 1'b1, out: 1'b1, eq: 1'b0, lt: 1'b1, lat: 2};
        vecs[3] = '{a: 4'd8,  b: 4'd7,  op: 2'b01, sgn: 1'b0, out: 1'b0, eq: 1'b0, lt: 1'b0, lat: 2};
        vecs[4] = '{a: 4'd3,  b: 4'd2,  op: 2'b10, sgn: 1'b0, out: 1'b0, eq: 1'b0, lt: 1'b0, lat: 5};
        vecs[5] = '{a: 4'd2,  b: 4'd6,  op: 2'b01, sgn: 1'b0, out: 1'b1, eq: 1'b0, lt: 1'b1, lat: 3};
        vecs[6] = '{a: 4'd15, b: 4'd1,  op: 2'b11, sgn: 1'b1, out: 1'b0, eq: 1'b0, lt: 1'b1, lat: 2};
        vecs[7] = '{a: 4'd0,  b: 4'd0,  op: 2'b10, sgn: 1'b1, out: 1'b1, eq: 1'b1, lt: 1'b0, lat: 5};
        vecs[8] = '{a: 4'd12, b: 4'd14, op: 2'b10, sgn: 1'b1, out: 1'b1, eq: 1'b0, lt: 1'b1, lat: 4};

        rst_n       = 1'b0;
        start       = 1'b0;
        A           = '0;
        B           = '0;
        op          = 2'b00;
        signed_mode = 1'b0;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out",  int'(Out),  0);
        chk("reset_eq",   int'(eq),   0);
        chk("reset_lt",   int'(lt),   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, lat);
            chk($sformatf("vec%0d_lat", i),  lat,               vecs[i].lat);
            chk($sformatf("vec%0d_done", i), int'(done),        1);
            chk($sformatf("vec%0d_busy", i), int'(busy),        1);
            chk($sformatf("vec%0d_out", i),  int'(Out),         int'(vecs[i].out));
            chk($sformatf("vec%0d_eq", i),   int'(eq),          int'(vecs[i].eq));
            chk($sformatf("vec%0d_lt", i),   int'(lt),          int'(vecs[i].lt));
            finish_done();
            chk($sformatf("vec%0d_idle", i), int'(busy | done), 0);
        end

        // Start re-pulsed while busy, and a start held during DONE, are both ignored.
        A = 4'd3; B = 4'd2; op = 2'b10; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 4'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < W + 4) begin
            chk("busy_scan", int'(busy), 1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_lat",  lat,       5);
        chk("ign_out",  int'(Out), 0);
        chk("ign_busy", int'(busy), 1);
        start = 1'b1;
        A = 4'd4; B = 4'd4; op = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse_low", int'(done), 0);
        chk("start_in_done_ignored", int'(busy), 0);
        chk("out_hold", int'(Out), 0);

        // Reset mid-scan aborts without a done pulse.
        A = 4'd1; B = 4'd1; op = 2'b00; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out",  int'(Out),  0);
        chk("rst_eq",   int'(eq),   0);
        chk("rst_lt",   int'(lt),   0);
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rst_n = 1'b1;
            if (done) saw_done = 1;
        end
        chk("rst_no_done", saw_done, 0);
        issue(4'd2, 4'd1, 2'b11, 1'b0, lat);
        chk("post_rst_lat", lat,       4);
        chk("post_rst_out", int'(Out), 1);
        finish_done();

        // Sweep against the reference model.
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 2; s++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        model(4'(a), 4'(b), 2'(o), 1'(s), m_out, m_eq, m_lt, m_lat);
                        issue(4'(a), 4'(b), 2'(o), 1'(s), lat);
                        chk($sformatf("sw_lat op%0d s%0d a%0d b%0d", o, s, a, b), lat, m_lat);
                        chk($sformatf("sw_out op%0d s%0d a%0d b%0d", o, s, a, b),
                            int'(Out), int'(m_out));
                        chk($sformatf("sw_eq op%0d s%0d a%0d b%0d", o, s, a, b),
                            int'(eq), int'(m_eq));
                        chk($sformatf("sw_lt op%0d s%0d a%0d b%0d", o, s, a, b),
                            int'(lt), int'(m_lt));
                        finish_done();
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 A  input  WIDTH  first operand; captured on accepted start.
REQ-006 B  input  WIDTH  second operand; captured on accepted start.
REQ-007 op  input  2  operation: 00 EQ, 01 LT, 10 LE, 11 GT; captured on accepted start.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured on accepted start.
REQ-009 busy  output  1  high while a comparison is in progress, including the DONE cycle.
REQ-010 done  output  1  single-cycle pulse when the result becomes valid.
REQ-011 Out  output  1  result of the selected op, A op B.
REQ-012 eq  output  1  A == B for the last completed comparison.
REQ-013 lt  output  1  A < B under the captured signedness for the last completed comparison.

Function
REQ-014 FSM states IDLE, SCAN and DONE; the reset state is IDLE.
REQ-015 IDLE with start=1 at a clock edge: capture A, B, op and signed_mode, load bit index = WIDTH-1, go to SCAN.
REQ-016 start while busy=1 is ignored, with no effect on the captured operands or the running comparison.
REQ-017 SCAN: examine one bit per cycle, MSB first (index WIDTH-1 down to 0), comparing captured A[idx] and B[idx].
REQ-018 First differing bit: decide, go to DONE (early exit); remaining bits are not examined.
REQ-019 Unsigned decision: lt = 1 if A[idx]=0 and B[idx]=1; eq = 0.
REQ-020 Signed decision at idx = WIDTH-1: lt = 1 if A[idx]=1 and B[idx]=0; at lower idx, same as unsigned.
REQ-021 All bits equal after examining idx = 0: eq = 1, lt = 0, go to DONE.
REQ-022 Out = eq for EQ; lt for LT; lt|eq for LE; ~(lt|eq) for GT.
REQ-023 Out, eq and lt are registered and update only on the edge entering DONE; they hold until the next completion.
REQ-024 DONE lasts exactly one cycle with done=1, then returns to IDLE; a start in the DONE cycle is ignored.
REQ-025 Latency: k = bits examined (1..WIDTH); done is high in cycle k+1 after the accepting edge; worst case WIDTH+1 cycles.
REQ-026 Back-to-back: the earliest next accepted start is the first IDLE cycle after DONE.
REQ-027 Input changes on A, B, op or signed_mode after capture do not affect the running comparison.

Reset
REQ-028 rst_n=0 forces, asynchronously, state=IDLE, busy=0, done=0, Out=0, eq=0, lt=0, bit index=0 and captured operands=0.
REQ-029 Reset mid-SCAN or mid-DONE aborts the comparison without asserting done; the first start after rst_n rises is accepted normally.

Structure
REQ-030 The op encodings (EQ/LT/LE/GT) and the FSM state encoding are defined in shared package comparator_pkg.
REQ-031 The block is a single module with no sub-module; the bit index counter width is $clog2(WIDTH).

Verification
REQ-032 WIDTH=4, unsigned, A=5, B=5, op=EQ: done at cycle 5 after start, Out=1, eq=1, lt=0.
REQ-033 WIDTH=4, unsigned, A=8, B=7, op=GT: early exit at MSB, done at cycle 2, Out=1, lt=0.
REQ-034 WIDTH=4, signed, A=4'b1000 (-8), B=4'b0111 (7), op=LT: Out=1, lt=1; the same operands unsigned give Out=0.
REQ-035 WIDTH=4, A=3, B=2, op=LE: start re-pulsed with A=0 while busy is ignored; the result is Out=0, and busy and done follow REQ-009/REQ-024.
REQ-036 rst_n pulsed low during SCAN of A=1, B=1: no done pulse, all outputs read 0; the next start with A=2, B=1, op=GT gives Out=1.
REQ-037 Exhaustive sweep over A, B = 0..15 for each op and signed_mode: every Out matches a reference model, and latency matches REQ-025.
